// File: rtl/fsk_dac_buffer.sv
// fsk_dac_buffer: prefilled FIFO between the FSK word recovery stage and the DAC sample clock.
module fsk_dac_buffer #(
  parameter int DEPTH   = 8,
  parameter int PREFILL = 4
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic [15:0]              sig_use,
  input  logic                     word_valid,
  input  logic                     dac_tick,
  input  logic                     clr_flags,
  output logic [15:0]              sig_to_dac,
  output logic                     dac_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     playing
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] PRE  = CW'(PREFILL);
  typedef enum logic {FILL, PLAY} state_t;
  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   sig_q, sig_d;
  logic          dv_q, dv_d, ovf_q, ovf_d, unf_q, unf_d;
  logic          tick_play, pop, push, ovf_ev, unf_ev;
  always_comb begin
    tick_play = state_q == PLAY && dac_tick;
    pop       = tick_play && count_q != '0;
    unf_ev    = tick_play && count_q == '0;
    // a full FIFO still accepts a word when the same cycle frees a slot
    push      = word_valid && (count_q != FULL || pop);
    ovf_ev    = word_valid && !push;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    sig_d     = pop ? mem_q[rd_ptr_q] : sig_q;
    dv_d      = pop;
    ovf_d     = ovf_ev | (ovf_q & ~clr_flags);
    unf_d     = unf_ev | (unf_q & ~clr_flags);
  end
  always_comb begin
    state_d = unf_ev ? FILL : (state_q == FILL && count_q >= PRE) ? PLAY : state_q;
  end
  always_ff @(posedge sysclk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sig_q    <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sig_q    <= sig_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  always_ff @(posedge sysclk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= sig_use;
  end
  always_comb begin
    playing    = state_q == PLAY;
    sig_to_dac = sig_q;
    dac_valid  = dv_q;
    fifo_count = count_q;
    overflow   = ovf_q;
    underflow  = unf_q;
  end
endmodule
